// File: rtl/debug_pkg.sv
// Shared codes and types for the debugger byte protocol.
// Used by both the host link master and the target-side debugger.
package debug_pkg;

  typedef enum logic [7:0] {
    CMD_NOP       = 8'h00,
    CMD_ECHO      = 8'h01,
    CMD_MEM_WRITE = 8'h02,
    CMD_MEM_READ  = 8'h03
  } cmd_e;

  localparam int HDR_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_FETCH,
    ST_SEND_DATA,
    ST_SEND_PAD,
    ST_WAIT_RSP,
    ST_DONE
  } state_e;

  typedef struct packed {
    cmd_e        cmd;
    logic [15:0] addr;
    logic [15:0] len;
    logic [7:0]  value;
  } req_t;

  // Unknown command codes collapse to NOP.
  function automatic cmd_e decode_cmd(input logic [7:0] raw);
    case (raw)
      8'h01:   return CMD_ECHO;
      8'h02:   return CMD_MEM_WRITE;
      8'h03:   return CMD_MEM_READ;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/debug_tx_pacer.sv
// Paces bytes into the UART transmitter with a one-cycle guard
// after every strobe to cover the transmitter's busy rise latency.
module debug_tx_pacer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_req,
  input  logic [7:0] byte_in,
  output logic       byte_ack,
  input  logic       tx_busy,
  output logic       tx_dv,
  output logic [7:0] tx_byte
);

  assign byte_ack = byte_req && !tx_busy && !tx_dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dv   <= 1'b0;
      tx_byte <= '0;
    end else begin
      tx_dv   <= byte_ack;
      tx_byte <= byte_ack ? byte_in : 8'h00;
    end
  end

endmodule

// File: rtl/debug_host.sv
// Host-side debugger link master: serialises one request into the
// command byte stream and collects the indexed response bytes.
module debug_host
  import debug_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TIMEOUT_W      = 17
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_cmd,
  input  logic [15:0] i_req_address,
  input  logic [15:0] i_req_length,
  input  logic [7:0]  i_req_value,
  output logic [15:0] o_src_index,
  output logic        o_src_rd,
  input  logic [7:0]  i_src_data,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_busy,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_rsp_dv,
  output logic [7:0]  o_rsp_byte,
  output logic [15:0] o_rsp_index,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state;
  req_t                 req;
  logic [2:0]           hdr_cnt;
  logic [15:0]          pad_cnt;
  logic [15:0]          rsp_cnt;
  logic [15:0]          exp_cnt;
  logic [7:0]           hold;
  logic                 have;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  logic       byte_req;
  logic [7:0] byte_in;
  logic       byte_ack;
  cmd_e       cmd_in;
  logic [7:0] hdr_byte;
  logic [2:0] hdr_last;
  state_e     post_hdr;
  logic       collect;
  logic       rsp_last;

  assign cmd_in      = decode_cmd(i_req_cmd);
  assign o_req_ready = (state == ST_IDLE);

  assign collect  = (state == ST_SEND_PAD || state == ST_WAIT_RSP)
                    && i_rx_dv && (rsp_cnt < exp_cnt);
  assign rsp_last = collect && (rsp_cnt == exp_cnt - 16'd1);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt)
      3'd0:    hdr_byte = req.cmd;
      3'd1:    hdr_byte = (req.cmd == CMD_ECHO) ? req.value
                                                : req.addr[15:8];
      3'd2:    hdr_byte = req.addr[7:0];
      3'd3:    hdr_byte = req.len[15:8];
      default: hdr_byte = req.len[7:0];
    endcase
  end

  always_comb begin
    hdr_last = 3'(HDR_LEN - 1);
    post_hdr = ST_DONE;
    unique case (req.cmd)
      CMD_NOP: hdr_last = 3'd0;
      CMD_ECHO: begin
        hdr_last = 3'd1;
        post_hdr = ST_SEND_PAD;
      end
      CMD_MEM_WRITE:
        post_hdr = (req.len == 16'd0) ? ST_DONE : ST_FETCH;
      CMD_MEM_READ:
        post_hdr = (req.len == 16'd0) ? ST_DONE : ST_SEND_PAD;
      default: ;
    endcase
  end

  // The command byte is offered straight from IDLE so it can
  // leave the cycle after capture.
  always_comb begin
    byte_req = 1'b0;
    byte_in  = 8'h00;
    unique case (state)
      ST_IDLE: begin
        byte_req = i_req_valid;
        byte_in  = cmd_in;
      end
      ST_SEND_HDR: begin
        byte_req = 1'b1;
        byte_in  = hdr_byte;
      end
      ST_SEND_DATA: begin
        byte_req = have;
        byte_in  = hold;
      end
      ST_SEND_PAD: begin
        byte_req = 1'b1;
        byte_in  = PAD_BYTE;
      end
      default: ;
    endcase
  end

  debug_tx_pacer u_pacer (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .byte_req (byte_req),
    .byte_in  (byte_in),
    .byte_ack (byte_ack),
    .tx_busy  (i_tx_busy),
    .tx_dv    (o_tx_dv),
    .tx_byte  (o_tx_byte)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      req         <= '0;
      hdr_cnt     <= '0;
      pad_cnt     <= '0;
      rsp_cnt     <= '0;
      exp_cnt     <= '0;
      hold        <= '0;
      have        <= 1'b0;
      tmo_cnt     <= '0;
      o_src_index <= '0;
      o_src_rd    <= 1'b0;
      o_rsp_dv    <= 1'b0;
      o_rsp_byte  <= '0;
      o_rsp_index <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_rsp_dv   <= 1'b0;
      o_rsp_byte <= 8'h00;
      o_src_rd   <= 1'b0;

      if (collect) begin
        o_rsp_dv    <= 1'b1;
        o_rsp_byte  <= i_rx_byte;
        o_rsp_index <= rsp_cnt;
        rsp_cnt     <= rsp_cnt + 16'd1;
      end

      unique case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            req     <= '{cmd:   cmd_in,
                         addr:  i_req_address,
                         len:   i_req_length,
                         value: i_req_value};
            hdr_cnt <= byte_ack ? 3'd1 : 3'd0;
            pad_cnt <= '0;
            rsp_cnt <= '0;
            unique case (cmd_in)
              CMD_ECHO:     exp_cnt <= 16'd1;
              CMD_MEM_READ: exp_cnt <= i_req_length;
              default:      exp_cnt <= 16'd0;
            endcase
            state <= (byte_ack && cmd_in == CMD_NOP)
                     ? ST_DONE : ST_SEND_HDR;
          end
        end

        ST_SEND_HDR: begin
          if (byte_ack) begin
            if (hdr_cnt == hdr_last) begin
              state   <= post_hdr;
              tmo_cnt <= '0;
              if (post_hdr == ST_FETCH) begin
                o_src_rd    <= 1'b1;
                o_src_index <= 16'd0;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
            end
          end
        end

        ST_FETCH: begin
          have  <= 1'b0;
          state <= ST_SEND_DATA;
        end

        // First cycle captures the source byte, then it is offered.
        ST_SEND_DATA: begin
          if (!have) begin
            hold <= i_src_data;
            have <= 1'b1;
          end else if (byte_ack) begin
            if (o_src_index == req.len - 16'd1) begin
              state <= ST_DONE;
            end else begin
              o_src_index <= o_src_index + 16'd1;
              o_src_rd    <= 1'b1;
              state       <= ST_FETCH;
            end
          end
        end

        ST_SEND_PAD: begin
          if (rsp_last) begin
            state <= ST_DONE;
          end else if (byte_ack) begin
            if (pad_cnt == exp_cnt - 16'd1) begin
              state   <= ST_WAIT_RSP;
              tmo_cnt <= '0;
            end else begin
              pad_cnt <= pad_cnt + 16'd1;
            end
          end
        end

        ST_WAIT_RSP: begin
          if (rsp_last) begin
            state <= ST_DONE;
          end else if (i_rx_dv) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            o_done  <= 1'b1;
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// Directed bench for debug_host with a scoreboard of expected
// tx bytes, source reads, response bytes and completions.
module tb_debug_host;

  localparam int TMO = 64;

  typedef struct {
    logic [7:0]  b;
    logic [15:0] idx;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic err;
    int   kind;
  } done_t;

  localparam int K_TX  = 0;
  localparam int K_RSP = 1;
  localparam int K_TMO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_cmd;
  logic [15:0] i_req_address;
  logic [15:0] i_req_length;
  logic [7:0]  i_req_value;
  logic [15:0] o_src_index;
  logic        o_src_rd;
  logic [7:0]  i_src_data;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_busy;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_rsp_dv;
  logic [7:0]  o_rsp_byte;
  logic [15:0] o_rsp_index;
  logic        o_done;
  logic        o_error;

  debug_host #(
    .PAD_BYTE       (8'h00),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (17)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_cmd     (i_req_cmd),
    .i_req_address (i_req_address),
    .i_req_length  (i_req_length),
    .i_req_value   (i_req_value),
    .o_src_index   (o_src_index),
    .o_src_rd      (o_src_rd),
    .i_src_data    (i_src_data),
    .o_tx_dv       (o_tx_dv),
    .o_tx_byte     (o_tx_byte),
    .i_tx_busy     (i_tx_busy),
    .i_rx_dv       (i_rx_dv),
    .i_rx_byte     (i_rx_byte),
    .o_rsp_dv      (o_rsp_dv),
    .o_rsp_byte    (o_rsp_byte),
    .o_rsp_index   (o_rsp_index),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tx_q[$];
  logic [15:0] src_q[$];
  rsp_t        rsp_q[$];
  done_t       done_q[$];
  logic [7:0]  src_mem[4];

  int tx_seen = 0;
  int rsp_seen = 0;
  int done_seen = 0;
  int last_tx_cyc = 0;
  int last_rsp_cyc = 0;
  int last_rx_cyc = 0;
  bit busy_mode = 1'b0;
  int busy_cnt = 0;
  bit prev_busy = 1'b0;
  bit prev_dv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor, scoreboard and transmitter/source models.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tx_dv) begin
        tx_seen++;
        last_tx_cyc = cyc;
        chk("tx_guard", 32'({prev_busy, prev_dv}), 32'd0);
        chk("tx_expected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0)
          chk("tx_byte", 32'(o_tx_byte), 32'(tx_q.pop_front()));
      end else begin
        chk("tx_idle_zero", 32'(o_tx_byte), 32'd0);
      end
      if (o_src_rd) begin
        chk("src_expected", 32'(src_q.size() > 0), 32'd1);
        if (src_q.size() > 0)
          chk("src_index", 32'(o_src_index), 32'(src_q.pop_front()));
        i_src_data = src_mem[o_src_index[1:0]];
      end
      if (o_rsp_dv) begin
        rsp_t e;
        rsp_seen++;
        last_rsp_cyc = cyc;
        chk("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          chk("rsp_byte", 32'(o_rsp_byte), 32'(e.b));
          chk("rsp_index", 32'(o_rsp_index), 32'(e.idx));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("rsp_idle_zero", 32'(o_rsp_byte), 32'd0);
      end
      if (o_done) begin
        done_t d;
        done_seen++;
        chk("done_expected", 32'(done_q.size() > 0), 32'd1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          chk("done_error", 32'(o_error), 32'(d.err));
          if (d.kind == K_TX)
            chk("done_after_tx", 32'(cyc), 32'(last_tx_cyc + 1));
          else if (d.kind == K_RSP)
            chk("done_after_rsp", 32'(cyc), 32'(last_rsp_cyc + 1));
          else
            chk("done_timeout_cyc", 32'(cyc),
                32'(last_rx_cyc + TMO + 1));
        end
      end
    end
    if (busy_mode && o_tx_dv) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    i_tx_busy = (busy_cnt > 0);
    prev_busy = i_tx_busy;
    prev_dv   = o_tx_dv;
  end

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(b);
  endtask

  task automatic push_done(input logic err, input int kind);
    done_q.push_back('{err: err, kind: kind});
  endtask

  task automatic send_req(input logic [7:0] cmd,
                          input logic [15:0] addr,
                          input logic [15:0] len,
                          input logic [7:0] val);
    int n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(o_req_ready), 32'd1);
    i_req_valid   = 1'b1;
    i_req_cmd     = cmd;
    i_req_address = addr;
    i_req_length  = len;
    i_req_value   = val;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("ready_drop", 32'(o_req_ready), 32'd0);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_count", 32'(tx_seen >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int start = done_seen;
    int n = 0;
    while (done_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_seen - start), 32'd1);
  endtask

  task automatic rx(input logic [7:0] b, input bit expect_rsp,
                    input logic [15:0] idx);
    @(negedge clk);
    i_rx_dv     = 1'b1;
    i_rx_byte   = b;
    last_rx_cyc = cyc;
    if (expect_rsp)
      rsp_q.push_back('{b: b, idx: idx, cyc: cyc + 1});
    @(negedge clk);
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int snap;
    rst_n         = 1'b0;
    i_req_valid   = 1'b0;
    i_req_cmd     = 8'h00;
    i_req_address = 16'h0000;
    i_req_length  = 16'h0000;
    i_req_value   = 8'h00;
    i_src_data    = 8'h00;
    i_tx_busy     = 1'b0;
    i_rx_dv       = 1'b0;
    i_rx_byte     = 8'h00;
    src_mem       = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_outs", 32'({o_tx_dv, o_tx_byte, o_src_rd, o_src_index,
                         o_rsp_dv, o_done, o_error}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NOP
    push_tx(8'h00);
    push_done(1'b0, K_TX);
    send_req(8'h00, 16'h0000, 16'h0000, 8'h00);
    wait_done(50);

    // ECHO 5A
    base = tx_seen;
    push_tx(8'h01); push_tx(8'h5A); push_tx(8'h00);
    push_done(1'b0, K_RSP);
    send_req(8'h01, 16'h0000, 16'h0000, 8'h5A);
    wait_tx(base + 3, 50);
    rx(8'h5A, 1'b1, 16'd0);
    wait_done(50);

    // MEM_WRITE with a slow transmitter
    busy_mode = 1'b1;
    foreach (src_mem[i]) src_mem[i] = 8'hAA + 8'(i * 17);
    push_tx(8'h02); push_tx(8'h12); push_tx(8'h34);
    push_tx(8'h00); push_tx(8'h03);
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC);
    src_q.push_back(16'd0); src_q.push_back(16'd1);
    src_q.push_back(16'd2);
    push_done(1'b0, K_TX);
    send_req(8'h02, 16'h1234, 16'd3, 8'h00);
    wait_done(400);
    busy_mode = 1'b0;
    repeat (12) @(negedge clk);

    // MEM_READ len=2 with full response
    base = tx_seen;
    push_tx(8'h03); push_tx(8'h00); push_tx(8'h10);
    push_tx(8'h00); push_tx(8'h02); push_tx(8'h00); push_tx(8'h00);
    push_done(1'b0, K_RSP);
    send_req(8'h03, 16'h0010, 16'd2, 8'h00);
    wait_tx(base + 7, 60);
    rx(8'h11, 1'b1, 16'd0);
    rx(8'h22, 1'b1, 16'd1);
    wait_done(50);

    // Zero-length read and write, unknown command
    push_tx(8'h03); push_tx(8'h00); push_tx(8'h10);
    push_tx(8'h00); push_tx(8'h00);
    push_done(1'b0, K_TX);
    send_req(8'h03, 16'h0010, 16'd0, 8'h00);
    wait_done(50);
    push_tx(8'h02); push_tx(8'h00); push_tx(8'h20);
    push_tx(8'h00); push_tx(8'h00);
    push_done(1'b0, K_TX);
    send_req(8'h02, 16'h0020, 16'd0, 8'h00);
    wait_done(50);
    push_tx(8'h00);
    push_done(1'b0, K_TX);
    send_req(8'h09, 16'hFFFF, 16'd7, 8'h33);
    wait_done(50);

    // MEM_READ that times out after one response byte
    base = tx_seen;
    push_tx(8'h03); push_tx(8'h00); push_tx(8'h40);
    push_tx(8'h00); push_tx(8'h02); push_tx(8'h00); push_tx(8'h00);
    push_done(1'b1, K_TMO);
    send_req(8'h03, 16'h0040, 16'd2, 8'h00);
    wait_tx(base + 7, 60);
    repeat (3) @(negedge clk);
    rx(8'h77, 1'b1, 16'd0);
    wait_done(TMO + 50);
    push_tx(8'h00);
    push_done(1'b0, K_TX);
    send_req(8'h00, 16'h0000, 16'h0000, 8'h00);
    wait_done(50);

    // Reset in the middle of a MEM_WRITE payload
    busy_mode = 1'b1;
    src_mem = '{8'h01, 8'h02, 8'h03, 8'h04};
    base = tx_seen;
    push_tx(8'h02); push_tx(8'h00); push_tx(8'h00);
    push_tx(8'h00); push_tx(8'h04);
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03); push_tx(8'h04);
    for (int i = 0; i < 4; i++) src_q.push_back(16'(i));
    push_done(1'b0, K_TX);
    send_req(8'h02, 16'h0000, 16'd4, 8'h00);
    wait_tx(base + 6, 200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_req_ready), 32'd1);
    chk("mid_rst_outs", 32'({o_tx_dv, o_tx_byte, o_src_rd,
                             o_src_index, o_rsp_dv, o_rsp_byte,
                             o_done, o_error}), 32'd0);
    tx_q.delete();
    src_q.delete();
    done_q.delete();
    busy_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = done_seen;
    repeat (30) @(negedge clk);
    chk("no_done_after_rst", 32'(done_seen), 32'(snap));
    chk("ready_after_rst", 32'(o_req_ready), 32'd1);
    snap = rsp_seen;
    rx(8'h99, 1'b0, 16'd0);
    repeat (5) @(negedge clk);
    chk("idle_rx_dropped", 32'(rsp_seen), 32'(snap));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
